// File: rtl/imem_pkg.sv
// Shared constants and FSM encoding for the instruction-memory boot loader.
package imem_pkg;
  localparam int MEM_WORDS = 1024;
  localparam int ADDR_W    = 10;
  localparam int CNT_W     = ADDR_W + 1;  // word counter reaches MEM_WORDS without wrapping
  localparam int TO_W      = 16;          // idle-cycle counter, covers TIMEOUT_CYC up to 65535

  typedef enum logic [2:0] {
    HDR0  = 3'd0,
    HDR1  = 3'd1,
    LOAD  = 3'd2,
    CSUM  = 3'd3,
    DONE  = 3'd4,
    ERROR = 3'd5
  } state_e;
endpackage

// File: rtl/byte_packer.sv
// Assembles four little-endian bytes into one 32-bit word. The word is
// presented combinationally together with the 4th byte so the loader can
// register it straight into the imem write port.
module byte_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr_i,
  input  logic        byte_vld_i,
  input  logic [7:0]  byte_i,
  output logic        word_vld_o,
  output logic [31:0] word_o
);
  logic [1:0]  idx_q;
  logic [23:0] lo_q;

  // Capture the lower three bytes and track the byte lane
  always_ff @(posedge clk) begin
    if (reset || clr_i) begin
      idx_q <= '0;
      lo_q  <= '0;
    end else if (byte_vld_i) begin
      case (idx_q)
        2'd0:    lo_q[7:0]   <= byte_i;
        2'd1:    lo_q[15:8]  <= byte_i;
        2'd2:    lo_q[23:16] <= byte_i;
        default: ;
      endcase
      idx_q <= idx_q + 2'd1;
    end
  end

  assign word_vld_o = byte_vld_i && (idx_q == 2'd3);
  assign word_o     = {byte_i, lo_q};
endmodule

// File: rtl/imem_loader.sv
// Boot-time imem writer: header (16-bit LE word count) then 4*N data bytes.
// Holds the CPU in reset until the load finishes cleanly.
// Optional trailing XOR checksum byte: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader import imem_pkg::*; #(
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  input  logic              start,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);
  localparam logic [31:0] TO_LIM = 32'(TIMEOUT_CYC);

  state_e             state_q, state_d;
  logic [15:0]        n_q, n_d;
  logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic [TO_W-1:0]    to_q, to_d;
  logic               s_ready_q, mem_we_q, cpu_hold_q, done_q, error_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [31:0]        mem_wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]         csum_q, csum_d;
`endif

  logic        hs, pk_vld, last_word;
  logic [31:0] pk_word;
  logic [15:0] n_hdr;

  assign hs        = s_valid && s_ready_q;
  assign n_hdr     = {s_data, n_q[7:0]};
  assign last_word = (16'(word_cnt_q) + 16'd1) == n_q;

  byte_packer u_pack (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (state_q != LOAD),
    .byte_vld_i (hs && (state_q == LOAD)),
    .byte_i     (s_data),
    .word_vld_o (pk_vld),
    .word_o     (pk_word)
  );

  // Next-state: header decode, word counting, checksum, re-arm and idle timeout
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    word_cnt_d = word_cnt_q;
    to_d       = to_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    case (state_q)
      HDR0: if (hs) begin
        n_d     = {8'h00, s_data};
        state_d = HDR1;
      end
      HDR1: if (hs) begin
        n_d     = n_hdr;
        state_d = (n_hdr == 16'd0 || n_hdr > 16'(MEM_WORDS)) ? ERROR : LOAD;
      end
      LOAD: if (hs) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d = csum_q ^ s_data;
`endif
        if (pk_vld) begin
          word_cnt_d = word_cnt_q + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          if (last_word) state_d = CSUM;
`else
          if (last_word) state_d = DONE;
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CSUM: if (hs) state_d = (s_data == csum_q) ? DONE : ERROR;
`endif
      DONE, ERROR: if (start) begin
        state_d    = HDR0;
        n_d        = '0;
        word_cnt_d = '0;
        to_d       = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d     = '0;
`endif
      end
      default: state_d = ERROR;
    endcase

    // Once a load has started the host must keep bytes flowing
    if (state_q inside {HDR1, LOAD, CSUM}) begin
      if (hs || TO_LIM == 32'd0) begin
        to_d = '0;
      end else if (32'(to_q) + 32'd1 == TO_LIM) begin
        to_d    = '0;
        state_d = ERROR;
      end else begin
        to_d = to_q + 1'b1;
      end
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= HDR0;
      n_q         <= '0;
      word_cnt_q  <= '0;
      to_q        <= '0;
      s_ready_q   <= 1'b1;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_hold_q  <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      word_cnt_q <= word_cnt_d;
      to_q       <= to_d;
      mem_we_q   <= pk_vld;
      if (pk_vld) begin
        mem_addr_q  <= word_cnt_q[ADDR_W-1:0];
        mem_wdata_q <= pk_word;
      end
      s_ready_q  <= state_d inside {HDR0, HDR1, LOAD, CSUM};
      cpu_hold_q <= state_d != DONE;
      done_q     <= state_d == DONE;
      error_q    <= state_d == ERROR;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign s_ready   = s_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_hold  = cpu_hold_q;
  assign done      = done_q;
  assign error     = error_q;
endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: header table, hand-written corner sequences and
// randomized loads checked against an expected word list.
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_ready;
  logic        start = 1'b0;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold, done, error;

  int total = 0;
  int bad   = 0;

  logic [9:0]  cap_addr[$];
  logic [31:0] cap_data[$];
  logic [31:0] exp_words[$];

  imem_loader #(.TIMEOUT_CYC(8)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .start(start), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // write-port monitor
  always @(negedge clk) begin
    if (mem_we) begin
      cap_addr.push_back(mem_addr);
      cap_data.push_back(mem_wdata);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // {s_ready, cpu_hold, done, error}
  task automatic chk_stat(input string nm, input logic [3:0] exp);
    chk(nm, 64'({s_ready, cpu_hold, done, error}), 64'(exp));
  endtask

  task automatic step(input logic v, input logic [7:0] d);
    @(negedge clk);
    s_valid = v;
    s_data  = d;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'h00);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; s_valid = 1'b0; start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    cap_addr.delete(); cap_data.delete();
  endtask

  task automatic pulse_start();
    @(negedge clk);
    s_valid = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Sends header + exp_words (+ checksum) and compares against the model:
  // words land at 0..N-1 in order; final status from checksum correctness.
  task automatic run_load(input string nm, input int n, input int gmax,
                          input bit bad_csum, input bit poke_start);
    logic [7:0] x, b8;
    logic [15:0] n16;
    x = 8'h00;
    n16 = 16'(n);
    cap_addr.delete(); cap_data.delete();
    step(1'b1, n16[7:0]);
    step(1'b1, n16[15:8]);
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < 4; b++) begin
        if (gmax > 0) idle(int'($urandom_range(0, gmax)));
        b8 = exp_words[i][8*b +: 8];
        x ^= b8;
        step(1'b1, b8);
        start = (poke_start && i == 0 && b == 1);
      end
    end
    start = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    step(1'b1, bad_csum ? (x ^ 8'h01) : x);
`endif
    idle(3);
    chk({nm, " nwr"}, 64'(cap_addr.size()), 64'(n));
    for (int i = 0; i < n && i < cap_addr.size(); i++) begin
      chk({nm, " addr"}, 64'(cap_addr[i]), 64'(i));
      chk({nm, " data"}, 64'(cap_data[i]), 64'(exp_words[i]));
    end
    chk_stat({nm, " status"}, bad_csum ? 4'b0101 : 4'b0010);
  endtask

  typedef struct {
    string      nm;
    logic [7:0] lo;
    logic [7:0] hi;
    logic       exp_err;
  } hdr_t;
  hdr_t tbl[5];

  initial begin
    tbl[0] = '{"hdr N=0",    8'h00, 8'h00, 1'b1};
    tbl[1] = '{"hdr N=1025", 8'h01, 8'h04, 1'b1};
    tbl[2] = '{"hdr N=1024", 8'h00, 8'h04, 1'b0};
    tbl[3] = '{"hdr N=ffff", 8'hff, 8'hff, 1'b1};
    tbl[4] = '{"hdr N=1",    8'h01, 8'h00, 1'b0};

    // reset state
    do_reset();
    chk_stat("reset status", 4'b1100);
    chk("reset we",    64'(mem_we), 64'(0));
    chk("reset addr",  64'(mem_addr), 64'(0));
    chk("reset wdata", 64'(mem_wdata), 64'(0));
    idle(20);
    chk_stat("hdr0 no timeout", 4'b1100);

    // two-word load with write latency check
    cap_addr.delete(); cap_data.delete();
    step(1'b1, 8'h02); step(1'b1, 8'h00);
    step(1'b1, 8'h13); step(1'b1, 8'h00); step(1'b1, 8'h00);
    step(1'b1, 8'h00);
    chk("we before 4th", 64'(mem_we), 64'(0));
    step(1'b1, 8'h93);
    chk("w0 we",   64'(mem_we), 64'(1));
    chk("w0 addr", 64'(mem_addr), 64'(0));
    chk("w0 data", 64'(mem_wdata), 64'h13);
    step(1'b1, 8'h00);
    chk("w0 pulse", 64'(mem_we), 64'(0));
    step(1'b1, 8'h10); step(1'b1, 8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
    step(1'b1, 8'h93 ^ 8'h10 ^ 8'h13);
`endif
    step(1'b0, 8'h00);
`ifndef IMEM_LOADER_CHECKSUM_EN
    chk("w1 addr", 64'(mem_addr), 64'(1));
    chk("w1 data", 64'(mem_wdata), 64'h00100093);
`endif
    idle(2);
    chk("two-word nwr", 64'(cap_addr.size()), 64'(2));
    chk_stat("two-word status", 4'b0010);

    // bytes offered in DONE are not consumed
    cap_addr.delete(); cap_data.delete();
    step(1'b1, 8'haa); step(1'b1, 8'h55); step(1'b1, 8'h01); step(1'b1, 8'h00);
    idle(2);
    chk("done ignores bytes", 64'(cap_addr.size()), 64'(0));
    chk_stat("done holds", 4'b0010);
    pulse_start();
    chk_stat("start rearm", 4'b1100);

    // header table
    foreach (tbl[k]) begin
      do_reset();
      step(1'b1, tbl[k].lo);
      step(1'b1, tbl[k].hi);
      step(1'b0, 8'h00);
      chk_stat(tbl[k].nm, tbl[k].exp_err ? 4'b0101 : 4'b1100);
      chk({tbl[k].nm, " no we"}, 64'(cap_addr.size()), 64'(0));
    end

    // randomized loads
    do_reset();
    for (int r = 0; r < 6; r++) begin
      int n;
      n = int'($urandom_range(1, 24));
      exp_words.delete();
      for (int i = 0; i < n; i++) exp_words.push_back($urandom);
      run_load($sformatf("rand%0d", r), n, 3, 1'b0, r == 2);
      pulse_start();
    end

    // full-depth load
    exp_words.delete();
    for (int i = 0; i < 1024; i++) exp_words.push_back($urandom);
    run_load("full", 1024, 0, 1'b0, 1'b0);
    if (cap_addr.size() > 0)
      chk("full last addr", 64'(cap_addr[cap_addr.size()-1]), 64'(1023));
    pulse_start();

    // stall mid-word past the timeout
    step(1'b1, 8'h02); step(1'b1, 8'h00);
    step(1'b1, 8'hde); step(1'b1, 8'had);
    idle(5);
    chk_stat("stall short", 4'b1100);
    idle(5);
    chk_stat("stall timeout", 4'b0101);
    pulse_start();
    chk_stat("timeout rearm", 4'b1100);
    exp_words.delete();
    exp_words.push_back(32'hcafef00d);
    run_load("after timeout", 1, 2, 1'b0, 1'b0);
    pulse_start();

    // reset in the middle of a load
    step(1'b1, 8'h02); step(1'b1, 8'h00);
    step(1'b1, 8'h01); step(1'b1, 8'h02); step(1'b1, 8'h03); step(1'b1, 8'h04);
    @(negedge clk);
    reset = 1'b1; s_valid = 1'b0;
    @(negedge clk);
    chk_stat("midreset status", 4'b1100);
    chk("midreset we",    64'(mem_we), 64'(0));
    chk("midreset addr",  64'(mem_addr), 64'(0));
    chk("midreset wdata", 64'(mem_wdata), 64'(0));
    reset = 1'b0;
    exp_words.delete();
    for (int i = 0; i < 3; i++) exp_words.push_back($urandom);
    run_load("after reset", 3, 1, 1'b0, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    pulse_start();
    exp_words.delete();
    exp_words.push_back(32'h44332211);
    run_load("csum good", 1, 0, 1'b0, 1'b0);
    pulse_start();
    run_load("csum bad", 1, 0, 1'b1, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
